// File: rtl/booth8_pkg.sv
// Shared definitions for the radix-8 Booth operand encoder: the 5-bit
// selection digit format and the per-group recoding function.
package booth8_pkg;

  // Digit layout: bit 4 = negate, bits 3..0 = one-hot {4X,3X,2X,X}
  localparam int NEG_BIT = 4;

  typedef logic [4:0] booth_digit_t;

  localparam booth_digit_t DIG_ZERO = 5'b00000;
  localparam booth_digit_t DIG_P1   = 5'b00001;
  localparam booth_digit_t DIG_P2   = 5'b00010;
  localparam booth_digit_t DIG_P3   = 5'b00100;
  localparam booth_digit_t DIG_P4   = 5'b01000;
  localparam booth_digit_t DIG_M1   = 5'b10001;
  localparam booth_digit_t DIG_M2   = 5'b10010;
  localparam booth_digit_t DIG_M3   = 5'b10100;
  localparam booth_digit_t DIG_M4   = 5'b11000;

  // grp = {y[3i+2], y[3i+1], y[3i], y[3i-1]}; value = -4*g3 + 2*g2 + g1 + g0.
  // Both all-zero and all-one groups map to DIG_ZERO so "-0" never appears.
  function automatic booth_digit_t booth8_recode(input logic [3:0] grp);
    booth_digit_t d;
    case (grp)
      4'b0000, 4'b1111: d = DIG_ZERO;
      4'b0001, 4'b0010: d = DIG_P1;
      4'b0011, 4'b0100: d = DIG_P2;
      4'b0101, 4'b0110: d = DIG_P3;
      4'b0111:          d = DIG_P4;
      4'b1000:          d = DIG_M4;
      4'b1001, 4'b1010: d = DIG_M3;
      4'b1011, 4'b1100: d = DIG_M2;
      4'b1101, 4'b1110: d = DIG_M1;
      default:          d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth8_recoder.sv
// Combinational radix-8 Booth recoder: multiplier Y -> NUM_PP selection digits.
// Y is zero-extended to 3*NUM_PP bits so the most significant digit is never
// negative, and a zero is appended below bit 0 to supply y[-1].
module booth8_recoder
  import booth8_pkg::*;
#(
  parameter int NBIT   = 24,
  parameter int NUM_PP = (NBIT + 3) / 3
) (
  input  logic [NBIT-1:0]              y,
  output booth_digit_t [NUM_PP-1:0]    digits
);

  localparam int EXT_W = 3 * NUM_PP + 1;

  logic [EXT_W-1:0] y_ext;

  assign y_ext = {{(EXT_W - NBIT - 1){1'b0}}, y, 1'b0};

  for (genvar i = 0; i < NUM_PP; i++) begin : g_group
    assign digits[i] = booth8_recode(y_ext[3*i +: 4]);
  end

endmodule

// File: rtl/booth8_operand_encoder.sv
// Source side of the radix-8 Booth partial-product interface. Registers the
// operand pair, then produces X, 2X, 3X, 4X and the Booth digits in a second
// stage so the 3X carry-propagate adder has a full cycle to itself.
// Two-stage valid/ready pipeline, full throughput, outputs hold under stall.
module booth8_operand_encoder
  import booth8_pkg::*;
#(
  parameter int NBIT     = 24,
  parameter int NUM_PP   = (NBIT + 3) / 3,
  parameter int RES_NBIT = NBIT + 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NBIT-1:0]           x_in,
  input  logic [NBIT-1:0]           y_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RES_NBIT-1:0]       mul_x,
  output logic [RES_NBIT-1:0]       mul_2x,
  output logic [RES_NBIT-1:0]       mul_3x,
  output logic [RES_NBIT-1:0]       mul_4x,
  output logic [NUM_PP-1:0][4:0]    digits
);

  logic                        vld_p1;
  logic                        vld_p2;
  logic [NBIT-1:0]             x_p1;
  logic [NBIT-1:0]             y_p1;
  logic                        s2_load;
  logic [RES_NBIT-1:0]         x_ext;
  logic [RES_NBIT-1:0]         sum_3x;
  booth_digit_t [NUM_PP-1:0]   digits_comb;

  // Stage 2 accepts whenever it is empty or its content is being consumed;
  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign s2_load  = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || s2_load;
  assign out_valid = vld_p2;

  // ---- stage 1 -> stage 2 combinational work: hard multiple and recoding ----
  assign x_ext  = {{(RES_NBIT - NBIT){1'b0}}, x_p1};
  assign sum_3x = x_ext + (x_ext << 1);

  booth8_recoder #(
    .NBIT   (NBIT),
    .NUM_PP (NUM_PP)
  ) u_recoder (
    .y      (y_p1),
    .digits (digits_comb)
  );

  // ---- stage 1: capture the operand pair on an input transfer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (in_valid && in_ready) begin
        x_p1 <= x_in;
        y_p1 <= y_in;
      end
    end
  end

  // ---- stage 2: register multiples and digits; hold while stalled or idle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      mul_x  <= '0;
      mul_2x <= '0;
      mul_3x <= '0;
      mul_4x <= '0;
      digits <= '0;
    end else begin
      if (s2_load) vld_p2 <= vld_p1;
      if (vld_p1 && s2_load) begin
        mul_x  <= x_ext;
        mul_2x <= x_ext << 1;
        mul_3x <= sum_3x;
        mul_4x <= x_ext << 2;
        digits <= digits_comb;
      end
    end
  end

endmodule
